// File: rtl/rotame_pkg.sv
// rotame_pkg: rotation mode encodings, channel scheduler states and mode helpers
package rotame_pkg;
  localparam logic [3:0] MODE_R90  = 4'b0001;
  localparam logic [3:0] MODE_R180 = 4'b0010;
  localparam logic [3:0] MODE_R270 = 4'b0100;
  localparam logic [3:0] MODE_NONE = 4'b1000;
  typedef enum logic [1:0] {IDLE, ARM_WR, WR_FRAME, ARM_RD} state_e;
  function automatic logic is_onehot4(input logic [3:0] m);
    return m inside {MODE_R90, MODE_R180, MODE_R270, MODE_NONE};
  endfunction
  function automatic logic is_quarter(input logic [3:0] m);
    return m inside {MODE_R90, MODE_R270};
  endfunction
endpackage

// File: rtl/rotame_para_sched_if.sv
// rotame_para_sched_if: per-channel mode request, frame syncs and committed write/read parameters
interface rotame_para_sched_if #(
  parameter int NUM_CH      = 2,
  parameter int DIM_W       = 11,
  parameter int ADDR_W      = 28,
  parameter int BURST_SHIFT = 3
);
  logic [4*NUM_CH-1:0]                   mode_req;
  logic [DIM_W*NUM_CH-1:0]               s_width;
  logic [DIM_W*NUM_CH-1:0]               s_height;
  logic [NUM_CH-1:0]                     wr_vsync;
  logic [NUM_CH-1:0]                     rd_vsync;
  logic [4*NUM_CH-1:0]                   mode_wr;
  logic [4*NUM_CH-1:0]                   mode_rd;
  logic [DIM_W*NUM_CH-1:0]               t_width_wr;
  logic [DIM_W*NUM_CH-1:0]               t_height_wr;
  logic [DIM_W*NUM_CH-1:0]               t_width_rd;
  logic [DIM_W*NUM_CH-1:0]               t_height_rd;
  logic [ADDR_W*NUM_CH-1:0]              addr_max_wr;
  logic [ADDR_W*NUM_CH-1:0]              addr_max_rd;
  logic [(DIM_W-BURST_SHIFT)*NUM_CH-1:0] burst_len_wr;
  logic [(DIM_W-BURST_SHIFT)*NUM_CH-1:0] burst_len_rd;
  logic [NUM_CH-1:0]                     wr_vsync_out;
  logic [NUM_CH-1:0]                     rd_vsync_out;
  logic [NUM_CH-1:0]                     busy;
  logic [NUM_CH-1:0]                     err_mode;
  modport master (
    output mode_req, s_width, s_height, wr_vsync, rd_vsync,
    input  mode_wr, mode_rd, t_width_wr, t_height_wr, t_width_rd, t_height_rd,
           addr_max_wr, addr_max_rd, burst_len_wr, burst_len_rd,
           wr_vsync_out, rd_vsync_out, busy, err_mode
  );
  modport slave (
    input  mode_req, s_width, s_height, wr_vsync, rd_vsync,
    output mode_wr, mode_rd, t_width_wr, t_height_wr, t_width_rd, t_height_rd,
           addr_max_wr, addr_max_rd, burst_len_wr, burst_len_rd,
           wr_vsync_out, rd_vsync_out, busy, err_mode
  );
endinterface

// File: rtl/rotame_ch_sched.sv
// rotame_ch_sched: one channel's frame-boundary mode scheduler and write/read parameter registers
module rotame_ch_sched
  import rotame_pkg::*;
#(
  parameter int DIM_W       = 11,
  parameter int ADDR_W      = 28,
  parameter int BURST_SHIFT = 3,
  parameter int VS_DLY      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               mode_req,
  input  logic [DIM_W-1:0]         s_width,
  input  logic [DIM_W-1:0]         s_height,
  input  logic                     wr_vsync,
  input  logic                     rd_vsync,
  output logic [3:0]               mode_wr,
  output logic [3:0]               mode_rd,
  output logic [DIM_W-1:0]         t_width_wr,
  output logic [DIM_W-1:0]         t_height_wr,
  output logic [DIM_W-1:0]         t_width_rd,
  output logic [DIM_W-1:0]         t_height_rd,
  output logic [ADDR_W-1:0]        addr_max_wr,
  output logic [ADDR_W-1:0]        addr_max_rd,
  output logic [DIM_W-BURST_SHIFT-1:0] burst_len_wr,
  output logic [DIM_W-BURST_SHIFT-1:0] burst_len_rd,
  output logic                     wr_vsync_out,
  output logic                     rd_vsync_out,
  output logic                     busy,
  output logic                     err_mode
);
  localparam int PW = 2 * DIM_W;
  localparam int BW = DIM_W - BURST_SHIFT;
  state_e             state_q, state_d;
  logic [3:0]         req_d0_q, req_d0_d, req_d1_q, req_d1_d;
  logic [VS_DLY-1:0]  wr_sr_q, wr_sr_d, rd_sr_q, rd_sr_d;
  logic [3:0]         mode_wr_q, mode_wr_d, mode_rd_q, mode_rd_d;
  logic [DIM_W-1:0]   tw_wr_q, tw_wr_d, th_wr_q, th_wr_d, tw_rd_q, tw_rd_d, th_rd_q, th_rd_d;
  logic [ADDR_W-1:0]  amax_wr_q, amax_wr_d, amax_rd_q, amax_rd_d;
  logic [BW-1:0]      bl_wr_q, bl_wr_d, bl_rd_q, bl_rd_d;
  logic               busy_q, busy_d, err_q, err_d, bad_vld_q, bad_vld_d;
  logic [3:0]         bad_q, bad_d;
  logic [3:0]         req;
  logic               stable, legal, new_req, wr_edge, rd_edge, commit, rd_upd, swap;
  always_comb begin
    req       = req_d1_q;
    stable    = req_d0_q == req_d1_q;
    legal     = is_onehot4(req);
    new_req   = stable && legal && req != mode_wr_q;
    wr_edge   = wr_sr_q[1] & ~wr_sr_q[0];
    rd_edge   = rd_sr_q[1] & ~rd_sr_q[0];
    req_d0_d  = mode_req;
    req_d1_d  = req_d0_q;
    wr_sr_d   = {wr_sr_q[VS_DLY-2:0], wr_vsync};
    rd_sr_d   = {rd_sr_q[VS_DLY-2:0], rd_vsync};
    state_d   = state_q;
    mode_wr_d = mode_wr_q;
    unique case (state_q)
      IDLE:     state_d = new_req ? ARM_WR : IDLE;
      ARM_WR: begin
        if (wr_edge && new_req) begin
          mode_wr_d = req;
          state_d   = WR_FRAME;
        end else if (stable && req == mode_wr_q) begin
          state_d = IDLE;
        end
      end
      WR_FRAME: state_d = new_req ? ARM_WR : (wr_edge ? ARM_RD : WR_FRAME);
      ARM_RD:   state_d = rd_edge ? IDLE : (new_req ? ARM_WR : ARM_RD);
      default:  state_d = IDLE;
    endcase
    // the reader only moves to the new mode after a full frame was written in it
    commit    = state_q == ARM_RD && rd_edge;
    mode_rd_d = commit ? mode_wr_q : mode_rd_q;
    rd_upd    = rd_edge && state_q != WR_FRAME;
    swap      = is_quarter(mode_rd_d);
    tw_wr_d   = wr_edge ? s_width : tw_wr_q;
    th_wr_d   = wr_edge ? s_height : th_wr_q;
    tw_rd_d   = rd_upd ? (swap ? s_height : s_width) : tw_rd_q;
    th_rd_d   = rd_upd ? (swap ? s_width : s_height) : th_rd_q;
    amax_wr_d = ADDR_W'(PW'(tw_wr_q) * PW'(th_wr_q));
    amax_rd_d = ADDR_W'(PW'(tw_rd_q) * PW'(th_rd_q));
    bl_wr_d   = tw_wr_q[DIM_W-1:BURST_SHIFT];
    bl_rd_d   = tw_rd_q[DIM_W-1:BURST_SHIFT];
    // one pulse per distinct illegal value; a legal request re-arms reporting
    err_d     = stable && !legal && !(bad_vld_q && req == bad_q);
    bad_d     = err_d ? req : bad_q;
    bad_vld_d = (stable && legal) ? 1'b0 : (err_d || bad_vld_q);
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_d0_q  <= MODE_NONE;
      req_d1_q  <= MODE_NONE;
      wr_sr_q   <= '0;
      rd_sr_q   <= '0;
      mode_wr_q <= MODE_NONE;
      mode_rd_q <= MODE_NONE;
      tw_wr_q   <= '0;
      th_wr_q   <= '0;
      tw_rd_q   <= '0;
      th_rd_q   <= '0;
      amax_wr_q <= '0;
      amax_rd_q <= '0;
      bl_wr_q   <= '0;
      bl_rd_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      bad_q     <= '0;
      bad_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_d0_q  <= req_d0_d;
      req_d1_q  <= req_d1_d;
      wr_sr_q   <= wr_sr_d;
      rd_sr_q   <= rd_sr_d;
      mode_wr_q <= mode_wr_d;
      mode_rd_q <= mode_rd_d;
      tw_wr_q   <= tw_wr_d;
      th_wr_q   <= th_wr_d;
      tw_rd_q   <= tw_rd_d;
      th_rd_q   <= th_rd_d;
      amax_wr_q <= amax_wr_d;
      amax_rd_q <= amax_rd_d;
      bl_wr_q   <= bl_wr_d;
      bl_rd_q   <= bl_rd_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
      bad_vld_q <= bad_vld_d;
    end
  end
  assign mode_wr      = mode_wr_q;
  assign mode_rd      = mode_rd_q;
  assign t_width_wr   = tw_wr_q;
  assign t_height_wr  = th_wr_q;
  assign t_width_rd   = tw_rd_q;
  assign t_height_rd  = th_rd_q;
  assign addr_max_wr  = amax_wr_q;
  assign addr_max_rd  = amax_rd_q;
  assign burst_len_wr = bl_wr_q;
  assign burst_len_rd = bl_rd_q;
  assign wr_vsync_out = wr_sr_q[VS_DLY-1];
  assign rd_vsync_out = rd_sr_q[VS_DLY-1];
  assign busy         = busy_q;
  assign err_mode     = err_q;
endmodule

// File: rtl/rotame_para_sched.sv
// rotame_para_sched: NUM_CH independent frame-boundary rotation mode schedulers packed onto one bus
module rotame_para_sched
  import rotame_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIM_W       = 11,
  parameter int ADDR_W      = 28,
  parameter int BURST_SHIFT = 3,
  parameter int VS_DLY      = 8
) (
  input logic                  clk,
  input logic                  rst,
  rotame_para_sched_if.slave   bus
);
  localparam int BW = DIM_W - BURST_SHIFT;
  logic [NUM_CH-1:0][3:0]        mode_wr, mode_rd;
  logic [NUM_CH-1:0][DIM_W-1:0]  tw_wr, th_wr, tw_rd, th_rd;
  logic [NUM_CH-1:0][ADDR_W-1:0] amax_wr, amax_rd;
  logic [NUM_CH-1:0][BW-1:0]     bl_wr, bl_rd;
  logic [NUM_CH-1:0]             wvo, rvo, busy, err;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rotame_ch_sched #(
      .DIM_W(DIM_W), .ADDR_W(ADDR_W), .BURST_SHIFT(BURST_SHIFT), .VS_DLY(VS_DLY)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .mode_req     (bus.mode_req[4*i +: 4]),
      .s_width      (bus.s_width[DIM_W*i +: DIM_W]),
      .s_height     (bus.s_height[DIM_W*i +: DIM_W]),
      .wr_vsync     (bus.wr_vsync[i]),
      .rd_vsync     (bus.rd_vsync[i]),
      .mode_wr      (mode_wr[i]),
      .mode_rd      (mode_rd[i]),
      .t_width_wr   (tw_wr[i]),
      .t_height_wr  (th_wr[i]),
      .t_width_rd   (tw_rd[i]),
      .t_height_rd  (th_rd[i]),
      .addr_max_wr  (amax_wr[i]),
      .addr_max_rd  (amax_rd[i]),
      .burst_len_wr (bl_wr[i]),
      .burst_len_rd (bl_rd[i]),
      .wr_vsync_out (wvo[i]),
      .rd_vsync_out (rvo[i]),
      .busy         (busy[i]),
      .err_mode     (err[i])
    );
  end
  assign bus.mode_wr      = mode_wr;
  assign bus.mode_rd      = mode_rd;
  assign bus.t_width_wr   = tw_wr;
  assign bus.t_height_wr  = th_wr;
  assign bus.t_width_rd   = tw_rd;
  assign bus.t_height_rd  = th_rd;
  assign bus.addr_max_wr  = amax_wr;
  assign bus.addr_max_rd  = amax_rd;
  assign bus.burst_len_wr = bl_wr;
  assign bus.burst_len_rd = bl_rd;
  assign bus.wr_vsync_out = wvo;
  assign bus.rd_vsync_out = rvo;
  assign bus.busy         = busy;
  assign bus.err_mode     = err;
endmodule

// File: tb/tb_rotame_para_sched.sv
// tb_rotame_para_sched: directed plan steps then random traffic, checked each cycle against a timeline model
module tb_rotame_para_sched;
  import rotame_pkg::*;
  localparam int NUM_CH = 2, DIM_W = 11, ADDR_W = 28, BURST_SHIFT = 3, VS_DLY = 8;
  localparam int MAXC = 6000;
  localparam int P_IDLE = 0, P_ARMW = 1, P_WRF = 2, P_ARMR = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rotame_para_sched_if #(.NUM_CH(NUM_CH), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .BURST_SHIFT(BURST_SHIFT)) bus ();
  rotame_para_sched #(
    .NUM_CH(NUM_CH), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .BURST_SHIFT(BURST_SHIFT), .VS_DLY(VS_DLY)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0, n = 0, rst_n = 0;
  logic       vlog [2][NUM_CH][MAXC];
  logic [3:0] rlog [NUM_CH][MAXC];
  int         m_ph [NUM_CH];
  logic [3:0] m_wr [NUM_CH], m_rd [NUM_CH], m_bad [NUM_CH];
  logic       m_badv [NUM_CH], m_err [NUM_CH], m_busy [NUM_CH], m_wvo [NUM_CH], m_rvo [NUM_CH];
  longint     m_tww [NUM_CH], m_thw [NUM_CH], m_twr [NUM_CH], m_thr [NUM_CH];
  longint     m_aw [NUM_CH], m_ar [NUM_CH], m_bw [NUM_CH], m_br [NUM_CH];
  function automatic logic getv(input int s, input int c, input int i);
    if (i <= rst_n) return 1'b0;
    return vlog[s][c][i];
  endfunction
  function automatic logic [3:0] getr(input int c, input int i);
    if (i <= rst_n) return 4'd8;
    return rlog[c][i];
  endfunction
  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ch%0d obs=%0d exp=%0d", tag, c, obs, exp);
    end
  endtask
  task automatic model_reset();
    rst_n = n;
    for (int c = 0; c < NUM_CH; c++) begin
      m_ph[c] = P_IDLE; m_wr[c] = 4'd8; m_rd[c] = 4'd8; m_bad[c] = 4'd0; m_badv[c] = 1'b0;
      m_err[c] = 1'b0; m_busy[c] = 1'b0; m_wvo[c] = 1'b0; m_rvo[c] = 1'b0;
      m_tww[c] = 0; m_thw[c] = 0; m_twr[c] = 0; m_thr[c] = 0;
      m_aw[c] = 0; m_ar[c] = 0; m_bw[c] = 0; m_br[c] = 0;
    end
  endtask
  // one clock of the scheduler rules, driven by the logged input timeline
  task automatic model_step(input int c);
    logic [3:0] r1, r0;
    logic st, lg, want, we, re, commit, refresh;
    longint sw, sh;
    r1 = getr(c, n - 2); r0 = getr(c, n - 1);
    st = r1 == r0; lg = $countones(r1) == 1;
    want = st && lg && r1 != m_wr[c];
    we = getv(0, c, n - 2) && !getv(0, c, n - 1);
    re = getv(1, c, n - 2) && !getv(1, c, n - 1);
    sw = longint'(bus.s_width[DIM_W*c +: DIM_W]);
    sh = longint'(bus.s_height[DIM_W*c +: DIM_W]);
    m_aw[c] = (m_tww[c] * m_thw[c]) % (64'd1 << ADDR_W);
    m_ar[c] = (m_twr[c] * m_thr[c]) % (64'd1 << ADDR_W);
    m_bw[c] = m_tww[c] / (1 << BURST_SHIFT);
    m_br[c] = m_twr[c] / (1 << BURST_SHIFT);
    commit = re && m_ph[c] == P_ARMR;
    refresh = re && m_ph[c] != P_WRF;
    if (commit) m_rd[c] = m_wr[c];
    if (refresh) begin
      if (m_rd[c] == 4'd1 || m_rd[c] == 4'd4) begin m_twr[c] = sh; m_thr[c] = sw; end
      else begin m_twr[c] = sw; m_thr[c] = sh; end
    end
    if (we) begin m_tww[c] = sw; m_thw[c] = sh; end
    if (m_ph[c] == P_IDLE) begin
      if (want) m_ph[c] = P_ARMW;
    end else if (m_ph[c] == P_ARMW) begin
      if (we && want) begin m_wr[c] = r1; m_ph[c] = P_WRF; end
      else if (st && r1 == m_wr[c]) m_ph[c] = P_IDLE;
    end else if (m_ph[c] == P_WRF) begin
      if (want) m_ph[c] = P_ARMW; else if (we) m_ph[c] = P_ARMR;
    end else begin
      if (re) m_ph[c] = P_IDLE; else if (want) m_ph[c] = P_ARMW;
    end
    m_err[c] = st && !lg && !(m_badv[c] && r1 == m_bad[c]);
    if (m_err[c]) begin m_bad[c] = r1; m_badv[c] = 1'b1; end
    if (st && lg) m_badv[c] = 1'b0;
    m_busy[c] = m_ph[c] != P_IDLE;
    m_wvo[c] = getv(0, c, n - VS_DLY + 1);
    m_rvo[c] = getv(1, c, n - VS_DLY + 1);
  endtask
  task automatic check_ch(input int c);
    chk("mode_wr", c, bus.mode_wr[4*c +: 4], m_wr[c]);
    chk("mode_rd", c, bus.mode_rd[4*c +: 4], m_rd[c]);
    chk("t_width_wr", c, bus.t_width_wr[DIM_W*c +: DIM_W], m_tww[c]);
    chk("t_height_wr", c, bus.t_height_wr[DIM_W*c +: DIM_W], m_thw[c]);
    chk("t_width_rd", c, bus.t_width_rd[DIM_W*c +: DIM_W], m_twr[c]);
    chk("t_height_rd", c, bus.t_height_rd[DIM_W*c +: DIM_W], m_thr[c]);
    chk("addr_max_wr", c, bus.addr_max_wr[ADDR_W*c +: ADDR_W], m_aw[c]);
    chk("addr_max_rd", c, bus.addr_max_rd[ADDR_W*c +: ADDR_W], m_ar[c]);
    chk("burst_len_wr", c, bus.burst_len_wr[8*c +: 8], m_bw[c]);
    chk("burst_len_rd", c, bus.burst_len_rd[8*c +: 8], m_br[c]);
    chk("wr_vsync_out", c, bus.wr_vsync_out[c], m_wvo[c]);
    chk("rd_vsync_out", c, bus.rd_vsync_out[c], m_rvo[c]);
    chk("busy", c, bus.busy[c], m_busy[c]);
    chk("err_mode", c, bus.err_mode[c], m_err[c]);
  endtask
  task automatic tick();
    @(posedge clk);
    n++;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget obs=%0d exp<%0d", n, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    for (int c = 0; c < NUM_CH; c++) begin
      vlog[0][c][n] = bus.wr_vsync[c];
      vlog[1][c][n] = bus.rd_vsync[c];
      rlog[c][n] = bus.mode_req[4*c +: 4];
    end
    if (rst) model_reset();
    else for (int c = 0; c < NUM_CH; c++) model_step(c);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) check_ch(c);
  endtask
  task automatic frame(input logic [NUM_CH-1:0] wm, input logic [NUM_CH-1:0] rm);
    bus.wr_vsync = wm; bus.rd_vsync = rm;
    repeat (3) tick();
    bus.wr_vsync = '0; bus.rd_vsync = '0;
    repeat (12) tick();
  endtask
  task automatic set_req(input int c, input logic [3:0] m);
    bus.mode_req[4*c +: 4] = m;
  endtask
  initial begin
    int e;
    model_reset();
    bus.mode_req = {MODE_NONE, MODE_NONE};
    bus.s_width = {11'd1280, 11'd1280};
    bus.s_height = {11'd720, 11'd720};
    bus.wr_vsync = '0; bus.rd_vsync = '0;
    repeat (3) tick();
    chk("rst_mode_wr", 0, bus.mode_wr[3:0], 8);
    chk("rst_mode_rd", 1, bus.mode_rd[7:4], 8);
    chk("rst_busy", 0, bus.busy, 0);
    chk("rst_addr_max_wr", 0, bus.addr_max_wr[27:0], 0);
    rst = 1'b0;
    repeat (2) tick();
    frame(2'b11, 2'b11);
    chk("init_t_width_wr", 0, bus.t_width_wr[10:0], 1280);
    chk("init_addr_max_wr", 0, bus.addr_max_wr[27:0], 921600);
    chk("init_burst_len_wr", 0, bus.burst_len_wr[7:0], 160);
    chk("init_t_width_rd", 0, bus.t_width_rd[10:0], 1280);
    chk("init_addr_max_rd", 0, bus.addr_max_rd[27:0], 921600);
    chk("init_mode_rd", 0, bus.mode_rd[3:0], 8);
    set_req(0, MODE_R90);
    repeat (4) tick();
    chk("r90_busy", 0, bus.busy[0], 1);
    frame(2'b01, 2'b00);
    chk("r90_mode_wr", 0, bus.mode_wr[3:0], 1);
    chk("r90_mode_rd_early", 0, bus.mode_rd[3:0], 8);
    frame(2'b00, 2'b01);
    chk("r90_mode_rd_wrframe", 0, bus.mode_rd[3:0], 8);
    frame(2'b01, 2'b00);
    frame(2'b00, 2'b01);
    chk("r90_mode_rd", 0, bus.mode_rd[3:0], 1);
    chk("r90_t_width_rd", 0, bus.t_width_rd[10:0], 720);
    chk("r90_t_height_rd", 0, bus.t_height_rd[10:0], 1280);
    chk("r90_burst_len_rd", 0, bus.burst_len_rd[7:0], 90);
    chk("r90_busy_done", 0, bus.busy[0], 0);
    chk("indep_mode_rd", 1, bus.mode_rd[7:4], 8);
    chk("indep_t_width_rd", 1, bus.t_width_rd[21:11], 1280);
    set_req(1, MODE_R90);
    repeat (4) tick();
    frame(2'b10, 2'b00);
    set_req(1, MODE_R270);
    repeat (4) tick();
    chk("rearm_busy", 1, bus.busy[1], 1);
    frame(2'b10, 2'b00);
    chk("rearm_mode_wr", 1, bus.mode_wr[7:4], 4);
    frame(2'b00, 2'b10);
    chk("rearm_mode_rd_held", 1, bus.mode_rd[7:4], 8);
    frame(2'b10, 2'b00);
    frame(2'b00, 2'b10);
    chk("rearm_mode_rd", 1, bus.mode_rd[7:4], 4);
    chk("rearm_t_width_rd", 1, bus.t_width_rd[21:11], 720);
    set_req(0, 4'b0011);
    e = 0;
    repeat (10) begin tick(); e += int'(bus.err_mode[0]); end
    chk("illegal_err_pulses", 0, e, 1);
    chk("illegal_mode_wr", 0, bus.mode_wr[3:0], 1);
    chk("illegal_busy", 0, bus.busy[0], 0);
    set_req(0, MODE_R180);
    repeat (4) tick();
    frame(2'b01, 2'b01);
    chk("simul_mode_wr", 0, bus.mode_wr[3:0], 2);
    chk("simul_mode_rd", 0, bus.mode_rd[3:0], 1);
    rst = 1'b1;
    tick();
    chk("midrst_mode_wr", 0, bus.mode_wr[3:0], 8);
    chk("midrst_mode_rd", 0, bus.mode_rd[3:0], 8);
    chk("midrst_t_width_wr", 0, bus.t_width_wr[10:0], 0);
    chk("midrst_busy", 0, bus.busy, 0);
    rst = 1'b0;
    repeat (2000) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) bus.wr_vsync[c] = ~bus.wr_vsync[c];
        if ($urandom_range(0, 7) == 0) bus.rd_vsync[c] = ~bus.rd_vsync[c];
        if ($urandom_range(0, 39) == 0)
          set_req(c, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3)));
        if ($urandom_range(0, 99) == 0) begin
          bus.s_width[DIM_W*c +: DIM_W] = 11'($urandom_range(1, 2047));
          bus.s_height[DIM_W*c +: DIM_W] = 11'($urandom_range(1, 2047));
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
